// File: rtl/axi_fifo_video_pack.sv
// Packs RATIO input words into one wide word and buffers them in a first-word-fall-through FIFO.
// Define AXI_FIFO_VIDEO_PACK_LEVEL_EN to add the rd_level output (registered stored word count).
module axi_fifo_video_pack #(
  parameter int WR_DATA_WIDTH  = 32,
  parameter int RATIO          = 8,
  parameter int RD_DEPTH_WIDTH = 8,
  parameter int AF_THR         = (1 << RD_DEPTH_WIDTH) - 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [WR_DATA_WIDTH-1:0]          wr_data,
  output logic                              wr_vld,
  input  logic                              flush,
  input  logic                              rd_en,
  output logic                              rd_vld,
  output logic [WR_DATA_WIDTH*RATIO-1:0]    rd_data,
  output logic                              almost_full,
  output logic                              overflow
`ifdef AXI_FIFO_VIDEO_PACK_LEVEL_EN
  ,
  output logic [RD_DEPTH_WIDTH:0]           rd_level
`endif
);

  localparam int OW    = WR_DATA_WIDTH * RATIO;
  localparam int DEPTH = 1 << RD_DEPTH_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {EMPTY, VALID} out_state_t;

  out_state_t                state_q, state_d;
  logic [LW-1:0]             lane_q;
  logic [OW-1:0]             pack_q, pack_word, load_data;
  logic [OW-1:0]             mem [DEPTH];
  logic [RD_DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [RD_DEPTH_WIDTH:0]   count_q, count_next;
  logic                      wr_acc, last_lane, flush_hit, push, pop, load;

  // pack_q keeps unfilled lanes at zero, so a flushed word is padded for free.
  always_comb begin
    wr_acc    = wr_en & wr_vld;
    last_lane = (lane_q == LW'(RATIO - 1));
    pack_word = pack_q;
    if (wr_acc) pack_word[int'(lane_q)*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
    flush_hit = flush & wr_vld & (wr_acc | (lane_q != '0));
    push      = (wr_acc & last_lane) | flush_hit;
    pop       = rd_en & rd_vld;
    rd_ptr_nxt = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (push) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (wr_acc) begin
      lane_q <= lane_q + 1'b1;
      pack_q <= pack_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pack_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_vld      <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q     <= count_next;
      wr_vld      <= (count_next < (RD_DEPTH_WIDTH+1)'(DEPTH));
      almost_full <= (int'(count_next) >= AF_THR);
      if (wr_en && !wr_vld) overflow <= 1'b1;
    end
  end

  // Output register holds the head word; a push into empty storage bypasses the RAM.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_data = pack_word;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load    = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (pop) begin
          if (count_q > (RD_DEPTH_WIDTH+1)'(1)) begin
            load      = 1'b1;
            load_data = mem[rd_ptr_nxt];
          end else if (push) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) rd_data <= load_data;
    end
  end

  assign rd_vld = (state_q == VALID);

`ifdef AXI_FIFO_VIDEO_PACK_LEVEL_EN
  assign rd_level = count_q;
`endif

endmodule

// File: doc/axi_fifo_video_pack.md
AXI_FIFO_VIDEO_PACK -- requirements
Module: axi_fifo_video_pack

Interface
REQ-001 Parameter WR_DATA_WIDTH, default 32, input word width (1..256).
REQ-002 Parameter RATIO, default 8, input words per output word; power of two, 1..32.
REQ-003 Parameter RD_DEPTH_WIDTH, default 8, log2 of storage depth in output words (4..12).
REQ-004 Parameter AF_THR, default 2^RD_DEPTH_WIDTH-4, almost-full threshold in output words.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  WR_DATA_WIDTH  write word.
REQ-009 wr_vld  output  1  write space available; a write is accepted when wr_en and wr_vld are both high.
REQ-010 flush  input  1  pad and push the partial output word.
REQ-011 rd_en  input  1  read acknowledge; a pop occurs when rd_en and rd_vld are both high.
REQ-012 rd_vld  output  1  rd_data holds a valid word (first-word-fall-through).
REQ-013 rd_data  output  WR_DATA_WIDTH*RATIO  read word.
REQ-014 almost_full  output  1  stored word count >= AF_THR.
REQ-015 overflow  output  1  sticky write-while-not-ready flag.

Function
REQ-016 The packer shall hold a lane counter (0..RATIO-1); each accepted write fills lane k at bits [k*W +: W] and increments k, so the first word lands in the LSBs.
REQ-017 The write that fills lane RATIO-1 shall push the packed word into storage in the same cycle and return the lane counter to 0.
REQ-018 Storage shall hold 2^RD_DEPTH_WIDTH words (the output register included) in a circular buffer; pointers shall wrap modulo depth.
REQ-019 wr_vld shall be registered and high when stored count < 2^RD_DEPTH_WIDTH; a same-cycle pop shall not raise wr_vld before the next cycle.
REQ-020 A flush with wr_vld high and lane counter > 0 shall push the packed word with unfilled lanes zeroed, then reset the lane counter to 0.
REQ-021 A flush together with an accepted write shall include that write's word before padding; if the write completes the word, only one word is pushed.
REQ-022 A flush with lane counter 0 (after any same-cycle write), or with wr_vld low, shall be ignored.
REQ-023 The output stage shall have two states: EMPTY (rd_vld=0) and VALID (rd_vld=1). EMPTY goes to VALID the cycle after a word is present; VALID goes to EMPTY on a pop with no further stored word, else it reloads rd_data on the cycle after the pop.
REQ-024 Latency: a push into empty storage at cycle N shall give rd_vld=1 at cycle N+1.
REQ-025 rd_en while rd_vld=0 shall have no effect; rd_data shall hold its value while not popped.
REQ-026 A simultaneous push and pop shall leave the count unchanged.
REQ-027 wr_en while wr_vld=0 shall drop the word, leave the lane counter unchanged, and set overflow, which stays high until reset.
REQ-028 almost_full shall be registered and derived from the count after the current push/pop.

Reset
REQ-029 rst high shall asynchronously clear the pointers, count, and lane counter, and drive wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, overflow=0.
REQ-030 Reset mid-packing shall discard the partial word; the first write after reset shall land in lane 0.

Configuration
REQ-031 When macro AXI_FIFO_VIDEO_PACK_LEVEL_EN is defined, output rd_level [RD_DEPTH_WIDTH:0] shall be present, giving the registered stored word count (reset 0).
REQ-032 Without AXI_FIFO_VIDEO_PACK_LEVEL_EN, port rd_level and its logic shall be absent; all other behaviour is identical.

Verification
REQ-033 W=32, RATIO=8: write 0x1..0x8 consecutively -> one cycle later rd_vld=1 and rd_data=0x00000008_00000007_..._00000001.
REQ-034 Write 0xA, 0xB, then flush -> rd_data = 0x0000000B_0000000A with upper 192 bits zero; the next write lands in lane 0.
REQ-035 Depth 16, no reads, 128 writes -> wr_vld=0 after the 128th write; a 129th wr_en sets overflow=1; one pop -> wr_vld=1 on the following cycle.
REQ-036 Flush on the same cycle as the 8th write -> exactly one word is pushed; a flush with lane counter 0 -> no push.
REQ-037 Continuous writes with rd_en held high -> every word is read in order, none lost; almost_full toggles exactly at count AF_THR.
REQ-038 rst asserted after 3 writes -> all outputs reach reset values immediately; with AXI_FIFO_VIDEO_PACK_LEVEL_EN, rd_level=0.
